// File: rtl/regfile_write_queue_pkg.sv
// Shared types and constants for the register file write queue.
// An entry is a destination register plus the value to write there.
package regfile_write_queue_pkg;
   localparam int XLEN = 64;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;
endpackage

// File: rtl/regfile_write_queue_if.sv
// Bus bundle between the producers/decode side and the write queue.
// The master drives results and read addresses; the slave (the queue) drives the write port and forwarding.
interface regfile_write_queue_if #(parameter int DEPTH = 4);
   import regfile_write_queue_pkg::*;
   localparam int CW = $clog2(DEPTH + 1);

   logic              mem_valid;
   logic [REG_AW-1:0] mem_rd;
   logic [XLEN-1:0]   mem_data;
   logic              alu_valid;
   logic [REG_AW-1:0] alu_rd;
   logic [XLEN-1:0]   alu_data;
   logic              in_ready;
   logic              enable;
   logic [REG_AW-1:0] write_register;
   logic [XLEN-1:0]   reg_write_data;
   logic [REG_AW-1:0] fwd_rs1;
   logic [REG_AW-1:0] fwd_rs2;
   logic              fwd_hit_1;
   logic              fwd_hit_2;
   logic [XLEN-1:0]   fwd_data_1;
   logic [XLEN-1:0]   fwd_data_2;
   logic [CW-1:0]     count;
   logic              empty;

   modport master (
      output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, fwd_rs1, fwd_rs2,
      input  in_ready, enable, write_register, reg_write_data,
             fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2, count, empty
   );

   modport slave (
      input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, fwd_rs1, fwd_rs2,
      output in_ready, enable, write_register, reg_write_data,
             fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2, count, empty
   );
endinterface

// File: rtl/wb_entry_fifo.sv
// In-order circular buffer of pending writebacks: two ordered write ports, one read port,
// and a youngest-match search per forwarding port.
module wb_entry_fifo
   import regfile_write_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push_a,
   input  wb_entry_t              entry_a,
   input  logic                   push_b,
   input  wb_entry_t              entry_b,
   input  logic                   pop,
   output wb_entry_t              head_entry,
   output logic [CW-1:0]          count,
   input  logic [1:0][REG_AW-1:0] search_rd,
   output logic [1:0]             search_hit,
   output logic [1:0][XLEN-1:0]   search_data
);
   wb_entry_t     slots [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] tail_b;

   // Port b lands behind port a when both push, keeping the older entry in the older slot.
   assign tail_b = push_a ? tail + AW'(1) : tail;

   always_ff @(posedge clk) begin
      if (push_a)
         slots[tail] <= entry_a;
      if (push_b)
         slots[tail_b] <= entry_b;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(pop);
         tail  <= tail + AW'(push_a) + AW'(push_b);
         count <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
      end
   end

   assign head_entry = slots[head];

   // Scan oldest to youngest so a later match overrides an earlier one.
   always_comb begin
      search_hit  = '0;
      search_data = '0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count && slots[head + AW'(i)].rd == search_rd[p]) begin
               search_hit[p]  = 1'b1;
               search_data[p] = slots[head + AW'(i)].data;
            end
         end
      end
   end
endmodule

// File: rtl/regfile_write_queue.sv
// Write-side companion of the register file: queues ALU/load results, drains one per cycle
// onto the write port, and forwards pending values to decode.
module regfile_write_queue
   import regfile_write_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input logic                  clk,
   input logic                  rst,
   regfile_write_queue_if.slave bus
);
   localparam int CW = $clog2(DEPTH + 1);

   logic                   in_ready;
   logic                   mem_push;
   logic                   alu_push;
   logic                   pop;
   wb_entry_t              mem_entry;
   wb_entry_t              alu_entry;
   wb_entry_t              head_entry;
   logic [CW-1:0]          count;
   logic [1:0][REG_AW-1:0] fwd_rs;
   logic [1:0]             q_hit;
   logic [1:0][XLEN-1:0]   q_data;
   logic [1:0]             fwd_hit;
   logic [1:0][XLEN-1:0]   fwd_data;

   // Room for two is reserved so both producers can always land in the same cycle.
   assign in_ready = count <= CW'(DEPTH - 2);

   // Writes to x0 are consumed here and never reach the queue.
   assign mem_push  = bus.mem_valid && in_ready && (bus.mem_rd != '0);
   assign alu_push  = bus.alu_valid && in_ready && (bus.alu_rd != '0);
   assign mem_entry = '{rd: bus.mem_rd, data: bus.mem_data};
   assign alu_entry = '{rd: bus.alu_rd, data: bus.alu_data};
   assign pop       = count != '0;
   assign fwd_rs    = {bus.fwd_rs2, bus.fwd_rs1};

   wb_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_a      (mem_push),
      .entry_a     (mem_entry),
      .push_b      (alu_push),
      .entry_b     (alu_entry),
      .pop         (pop),
      .head_entry  (head_entry),
      .count       (count),
      .search_rd   (fwd_rs),
      .search_hit  (q_hit),
      .search_data (q_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.enable         <= 1'b0;
         bus.write_register <= '0;
         bus.reg_write_data <= '0;
      end else if (pop) begin
         bus.enable         <= 1'b1;
         bus.write_register <= head_entry.rd;
         bus.reg_write_data <= head_entry.data;
      end else begin
         bus.enable <= 1'b0;
      end
   end

   // The queue holds younger values than the output register, so it takes priority.
   always_comb begin
      fwd_hit  = '0;
      fwd_data = '0;
      for (int p = 0; p < 2; p++) begin
         if (fwd_rs[p] != '0) begin
            if (q_hit[p]) begin
               fwd_hit[p]  = 1'b1;
               fwd_data[p] = q_data[p];
            end else if (bus.enable && bus.write_register == fwd_rs[p]) begin
               fwd_hit[p]  = 1'b1;
               fwd_data[p] = bus.reg_write_data;
            end
         end
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.count      = count;
   assign bus.empty      = (count == '0) && !bus.enable;
   assign bus.fwd_hit_1  = fwd_hit[0];
   assign bus.fwd_hit_2  = fwd_hit[1];
   assign bus.fwd_data_1 = fwd_data[0];
   assign bus.fwd_data_2 = fwd_data[1];
endmodule

// File: tb/tb_regfile_write_queue.sv
// Scoreboard bench: accepted results are timestamped with the edge at which the register
// file must capture them; a negedge monitor checks writes, occupancy and forwarding.
module tb_regfile_write_queue;
   import regfile_write_queue_pkg::*;

   localparam int DEPTH = 4;

   typedef struct {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
      int                wr;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   regfile_write_queue_if #(.DEPTH(DEPTH)) bus ();

   regfile_write_queue #(.DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int   checks = 0;
   int   fails = 0;
   int   cyc = 0;
   int   last_wr = 0;
   int   model_count = 0;
   bit   model_ready = 1'b1;
   bit   model_took = 1'b0;
   exp_t pend[$];
   exp_t sb[$];
   exp_t popped;
   bit   exp_en;
   bit   exp_hit;
   logic [XLEN-1:0] exp_data;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, cyc);
      end
   endtask

   // An entry reaches the register file two edges after acceptance, or one edge after its predecessor.
   function void modelPush(input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data);
      exp_t e;
      if (rd != '0) begin
         e.rd   = rd;
         e.data = data;
         e.wr   = (cyc + 2 > last_wr + 1) ? cyc + 2 : last_wr + 1;
         last_wr = e.wr;
         pend.push_back(e);
         sb.push_back(e);
      end
   endfunction

   function automatic void expFwd(input logic [REG_AW-1:0] rs, output bit hit, output logic [XLEN-1:0] data);
      hit  = 1'b0;
      data = '0;
      if (rs != '0)
         foreach (pend[i])
            if (pend[i].rd == rs) begin
               hit  = 1'b1;
               data = pend[i].data;
            end
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pend.delete();
         sb.delete();
         model_ready = 1'b1;
         model_took  = 1'b0;
         model_count = 0;
      end else begin
         cyc++;
         model_took = model_ready;
         if (model_ready) begin
            if (bus.mem_valid) modelPush(bus.mem_rd, bus.mem_data);
            if (bus.alu_valid) modelPush(bus.alu_rd, bus.alu_data);
         end
         while (pend.size() > 0 && pend[0].wr <= cyc)
            void'(pend.pop_front());
         model_count = 0;
         foreach (pend[i])
            if (pend[i].wr - 1 > cyc) model_count++;
         model_ready = (model_count <= DEPTH - 2);
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         exp_en = (pend.size() > 0) && (pend[0].wr == cyc + 1);
         checkOutput("count", 64'(bus.count), 64'(model_count));
         checkOutput("in_ready", 64'(bus.in_ready), 64'(model_ready));
         checkOutput("enable", 64'(bus.enable), 64'(exp_en));
         checkOutput("empty", 64'(bus.empty), 64'((model_count == 0) && !exp_en));
         if (bus.enable) begin
            if (sb.size() == 0) begin
               checks++;
               fails++;
               $display("[TB] FAIL unexpected_write: got rd %0d, expected no write (edge %0d)", bus.write_register, cyc);
            end else begin
               popped = sb.pop_front();
               checkOutput("write_register", 64'(bus.write_register), 64'(popped.rd));
               checkOutput("reg_write_data", bus.reg_write_data, popped.data);
               checkOutput("write_edge", 64'(cyc + 1), 64'(popped.wr));
            end
         end
         expFwd(bus.fwd_rs1, exp_hit, exp_data);
         checkOutput("fwd_hit_1", 64'(bus.fwd_hit_1), 64'(exp_hit));
         checkOutput("fwd_data_1", bus.fwd_data_1, exp_data);
         expFwd(bus.fwd_rs2, exp_hit, exp_data);
         checkOutput("fwd_hit_2", 64'(bus.fwd_hit_2), 64'(exp_hit));
         checkOutput("fwd_data_2", bus.fwd_data_2, exp_data);
      end
   end

   task automatic driveCycle(input logic mv, input logic [REG_AW-1:0] mrd, input logic [XLEN-1:0] md,
                             input logic av, input logic [REG_AW-1:0] ard, input logic [XLEN-1:0] ad,
                             input logic [REG_AW-1:0] r1, input logic [REG_AW-1:0] r2);
      bus.mem_valid = mv;
      bus.mem_rd    = mrd;
      bus.mem_data  = md;
      bus.alu_valid = av;
      bus.alu_rd    = ard;
      bus.alu_data  = ad;
      bus.fwd_rs1   = r1;
      bus.fwd_rs2   = r2;
   endtask

   // Holds the payload until the edge at which it is accepted.
   task automatic applyStimulus(input logic mv, input logic [REG_AW-1:0] mrd, input logic [XLEN-1:0] md,
                                input logic av, input logic [REG_AW-1:0] ard, input logic [XLEN-1:0] ad,
                                input logic [REG_AW-1:0] r1, input logic [REG_AW-1:0] r2);
      driveCycle(mv, mrd, md, av, ard, ad, r1, r2);
      for (int i = 0; i < 32; i++) begin
         @(posedge clk);
         #1;
         if (model_took) return;
      end
      checks++;
      fails++;
      $display("[TB] FAIL accept_timeout: got no acceptance, expected one within 32 cycles");
      driveCycle(1'b0, '0, '0, 1'b0, '0, '0, r1, r2);
   endtask

   task automatic idle(input int n, input logic [REG_AW-1:0] r1, input logic [REG_AW-1:0] r2);
      driveCycle(1'b0, '0, '0, 1'b0, '0, '0, r1, r2);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [XLEN-1:0] randData();
      return {$urandom(), $urandom()};
   endfunction

   initial begin
      driveCycle(1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("reset_write_register", 64'(bus.write_register), 64'd0);
      checkOutput("reset_write_data", bus.reg_write_data, 64'd0);
      idle(5, 5'd0, 5'd5);

      applyStimulus(1'b0, 5'd0, '0, 1'b1, 5'd5, 64'hDEAD_BEEF, 5'd5, 5'd5);
      idle(4, 5'd5, 5'd5);

      applyStimulus(1'b1, 5'd3, 64'd1, 1'b1, 5'd3, 64'd2, 5'd3, 5'd3);
      idle(4, 5'd3, 5'd3);

      applyStimulus(1'b1, 5'd0, 64'hFF, 1'b1, 5'd0, 64'hFF, 5'd0, 5'd0);
      idle(3, 5'd0, 5'd0);

      for (int i = 0; i < 40; i++)
         applyStimulus(1'b1, 5'(1 + i % 15), randData(), 1'b1, 5'(16 + i % 15), randData(),
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      idle(6, 5'd1, 5'd16);

      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0)
            idle($urandom_range(1, 3), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         else
            applyStimulus(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), randData(),
                          1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), randData(),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      idle(8, 5'd1, 5'd2);

      applyStimulus(1'b1, 5'd7, randData(), 1'b1, 5'd9, randData(), 5'd7, 5'd9);
      applyStimulus(1'b1, 5'd10, randData(), 1'b1, 5'd11, randData(), 5'd7, 5'd9);
      driveCycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd7, 5'd11);
      rst = 1'b1;
      #1;
      checkOutput("rst_enable", 64'(bus.enable), 64'd0);
      checkOutput("rst_count", 64'(bus.count), 64'd0);
      checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd1);
      checkOutput("rst_empty", 64'(bus.empty), 64'd1);
      checkOutput("rst_write_register", 64'(bus.write_register), 64'd0);
      checkOutput("rst_fwd_hit_1", 64'(bus.fwd_hit_1), 64'd0);
      checkOutput("rst_fwd_hit_2", 64'(bus.fwd_hit_2), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      idle(6, 5'd7, 5'd11);

      checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
